// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_unit
//  Purpose  : Operand forwarding and load-use stall detection. Tracks
//             in-flight register writes (two ports per instruction) from
//             Execute down through NSTAGE later slots. Each Execute source
//             takes the youngest ready match or the register file value.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int DW       = 32,
  parameter int AW       = 4,
  parameter int NSRC     = 3,
  parameter int NSTAGE   = 2,
  parameter int LOAD_RDY = 2,
  parameter int PC_REG   = 15,
  localparam int SELW    = $clog2(2*NSTAGE+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     e_valid,
  input  logic [1:0]               e_we,
  input  logic [2*AW-1:0]          e_wa,
  input  logic                     e_is_load,
  input  logic                     flush_e,
  input  logic                     stall_e,
  input  logic [NSRC-1:0]          e_src_valid,
  input  logic [NSRC*AW-1:0]       e_src_addr,
  input  logic [NSRC*DW-1:0]       e_rd,
  input  logic [NSTAGE*2*DW-1:0]   stg_wd,
  input  logic [NSRC-1:0]          d_src_valid,
  input  logic [NSRC*AW-1:0]       d_src_addr,
  output logic [NSRC*SELW-1:0]     fwd_sel,
  output logic [NSRC*DW-1:0]       e_opnd,
  output logic                     ld_stall
);

  localparam logic [AW-1:0] C_PC_ADDR = AW'(PC_REG);

  // Slot descriptors; array index i holds slot k = i+1 (0 = Memory).
  logic [NSTAGE-1:0]              slot_valid_q, slot_valid_d;
  logic [NSTAGE-1:0][1:0]         slot_we_q,    slot_we_d;
  logic [NSTAGE-1:0][2*AW-1:0]    slot_wa_q,    slot_wa_d;
  logic [NSTAGE-1:0]              slot_ld_q,    slot_ld_d;

  logic                           scan_done;
  logic [SELW-1:0]                sel_code;
  logic [AW-1:0]                  src_a;

  // Next slot contents: Execute enters slot 1 unless killed or held, older slots shift down.
  always_comb begin
    slot_valid_d    = slot_valid_q;
    slot_we_d       = slot_we_q;
    slot_wa_d       = slot_wa_q;
    slot_ld_d       = slot_ld_q;
    slot_valid_d[0] = e_valid & ~flush_e & ~stall_e;
    slot_we_d[0]    = e_we;
    slot_wa_d[0]    = e_wa;
    slot_ld_d[0]    = e_is_load;
    for (int i = 1; i < NSTAGE; i++) begin
      slot_valid_d[i] = slot_valid_q[i-1];
      slot_we_d[i]    = slot_we_q[i-1];
      slot_wa_d[i]    = slot_wa_q[i-1];
      slot_ld_d[i]    = slot_ld_q[i-1];
    end
  end

  // Slot register; reset empties the pipe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid_q <= '0;
      slot_we_q    <= '0;
      slot_wa_q    <= '0;
      slot_ld_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_we_q    <= slot_we_d;
      slot_wa_q    <= slot_wa_d;
      slot_ld_q    <= slot_ld_d;
    end
  end

  // Per-source youngest-first scan; a not-ready load hit ends the scan with code 0.
  always_comb begin
    fwd_sel   = '0;
    e_opnd    = e_rd;
    scan_done = 1'b0;
    sel_code  = '0;
    src_a     = '0;
    for (int s = 0; s < NSRC; s++) begin
      scan_done = 1'b0;
      sel_code  = '0;
      src_a     = e_src_addr[s*AW +: AW];
      for (int i = 0; i < NSTAGE; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (!scan_done && slot_valid_q[i] && slot_we_q[i][p] && e_src_valid[s] &&
              (slot_wa_q[i][p*AW +: AW] == src_a) && (src_a != C_PC_ADDR)) begin
            scan_done = 1'b1;
            if (!((p == 0) && slot_ld_q[i] && ((i + 1) < LOAD_RDY)))
              sel_code = SELW'(1 + i*2 + p);
          end
        end
      end
      fwd_sel[s*SELW +: SELW] = sel_code;
      for (int c = 1; c <= 2*NSTAGE; c++) begin
        if (sel_code == SELW'(c))
          e_opnd[s*DW +: DW] = stg_wd[(c-1)*DW +: DW];
      end
    end
  end

  // Load-use stall: a Decode source would meet load data before it is forwardable.
  always_comb begin
    ld_stall = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (d_src_valid[s] && (d_src_addr[s*AW +: AW] != C_PC_ADDR)) begin
        if ((LOAD_RDY > 1) && e_valid && !flush_e && e_is_load && e_we[0] &&
            (e_wa[AW-1:0] == d_src_addr[s*AW +: AW]))
          ld_stall = 1'b1;
        for (int i = 0; i < NSTAGE; i++) begin
          if (slot_valid_q[i] && slot_ld_q[i] && slot_we_q[i][0] &&
              (slot_wa_q[i][AW-1:0] == d_src_addr[s*AW +: AW]) && ((i + 2) < LOAD_RDY))
            ld_stall = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_hazard_unit
//  Purpose  : Directed self-checking bench for fwd_hazard_unit with default
//             parameters (NSTAGE = 2, LOAD_RDY = 2, three sources).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int DW = 32, AW = 4, NSRC = 3, NSTAGE = 2, SELW = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   e_valid, e_is_load, flush_e, stall_e;
  logic [1:0]             e_we;
  logic [2*AW-1:0]        e_wa;
  logic [NSRC-1:0]        e_src_valid, d_src_valid;
  logic [NSRC*AW-1:0]     e_src_addr, d_src_addr;
  logic [NSRC*DW-1:0]     e_rd;
  logic [NSTAGE*2*DW-1:0] stg_wd;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic [NSRC*DW-1:0]     e_opnd;
  logic                   ld_stall;

  int nvec = 0;
  int nerr = 0;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_we(e_we), .e_wa(e_wa),
    .e_is_load(e_is_load), .flush_e(flush_e), .stall_e(stall_e),
    .e_src_valid(e_src_valid), .e_src_addr(e_src_addr), .e_rd(e_rd),
    .stg_wd(stg_wd), .d_src_valid(d_src_valid), .d_src_addr(d_src_addr),
    .fwd_sel(fwd_sel), .e_opnd(e_opnd), .ld_stall(ld_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and let outputs settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                       input logic ld);
    e_valid = 1'b1; e_we = we; e_wa = {wa1, wa0}; e_is_load = ld;
  endtask

  task automatic idle();
    e_valid = 1'b0; e_we = 2'b00; e_wa = '0; e_is_load = 1'b0;
  endtask

  // Source 0 in Execute.
  task automatic src0(input logic v, input logic [3:0] a);
    e_src_valid = {2'b00, v}; e_src_addr = {8'h00, a};
  endtask

  initial begin
    reset = 1'b0;
    idle();
    flush_e = 1'b0; stall_e = 1'b0;
    e_rd = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    stg_wd = {32'hF4F4_0004, 32'hF3F3_0003, 32'hF2F2_0002, 32'hF1F1_0001};
    d_src_valid = '0; d_src_addr = '0;
    src0(1'b1, 4'd3);

    // Reset state
    #3;
    chk("reset_sel",   fwd_sel, 9'd0);
    chk("reset_opnd",  e_opnd,  e_rd);
    chk("reset_stall", ld_stall, 1'b0);
    #4 reset = 1'b1;

    // Back-to-back ALU dependency: ADD r3, then SUB reads r3
    issue(2'b01, 4'd3, 4'd0, 1'b0);
    stg_wd[31:0] = 32'h11; stg_wd[95:64] = 32'h22;
    tick();
    issue(2'b00, 4'd0, 4'd0, 1'b0);
    #1;
    chk("alu_s1_sel",  fwd_sel, 9'd1);
    chk("alu_s1_opnd", e_opnd[31:0], 32'h11);
    tick();
    chk("alu_s2_sel",  fwd_sel, 9'd3);
    chk("alu_s2_opnd", e_opnd[31:0], 32'h22);

    // Priority: slot 1 and slot 2 both write r5; source 1 also reads r5
    issue(2'b01, 4'd5, 4'd0, 1'b0);
    tick(); tick();
    e_src_valid = 3'b011; e_src_addr = {4'd0, 4'd5, 4'd5};
    stg_wd[31:0] = 32'hAA; stg_wd[95:64] = 32'hBB;
    #1;
    chk("prio_sel",   fwd_sel, {3'd0, 3'd1, 3'd1});
    chk("prio_opnd0", e_opnd[31:0], 32'hAA);
    chk("prio_opnd1", e_opnd[63:32], 32'hAA);
    // Both ports of one instruction write r5: port 0 wins
    issue(2'b11, 4'd5, 4'd5, 1'b0);
    stg_wd[63:32] = 32'hCC;
    tick();
    chk("dual_sel",  fwd_sel, {3'd0, 3'd1, 3'd1});
    chk("dual_opnd", e_opnd[31:0], 32'hAA);
    // Drain: everything retires
    idle();
    tick(); tick();
    chk("drain_sel",  fwd_sel, 9'd0);
    chk("drain_opnd", e_opnd, e_rd);

    // Load-use: LDR r2 in Execute, Decode reads r2
    src0(1'b0, 4'd2);
    issue(2'b01, 4'd2, 4'd0, 1'b1);
    d_src_valid = 3'b001; d_src_addr = {8'h00, 4'd2};
    #1;
    chk("lu_exec_stall", ld_stall, 1'b1);
    tick();
    idle();
    #1;
    chk("lu_slot1_stall", ld_stall, 1'b0);
    // A dependent source meeting the load in slot 1 is not ready: code 0
    src0(1'b1, 4'd2);
    #1;
    chk("lu_notready_sel",  fwd_sel, 9'd0);
    chk("lu_notready_opnd", e_opnd[31:0], 32'h1111_0001);
    stg_wd[95:64] = 32'hDEAD_BEEF;
    tick();
    chk("lu_fwd_sel",  fwd_sel, 9'd3);
    chk("lu_fwd_opnd", e_opnd[31:0], 32'hDEAD_BEEF);
    // Flushed load and PC source never stall
    issue(2'b01, 4'd2, 4'd0, 1'b1);
    flush_e = 1'b1;
    #1;
    chk("lu_flush_stall", ld_stall, 1'b0);
    flush_e = 1'b0;
    issue(2'b01, 4'd15, 4'd0, 1'b1);
    d_src_addr = {8'h00, 4'd15};
    #1;
    chk("lu_pc_stall", ld_stall, 1'b0);
    idle();
    tick(); tick();

    // Base writeback: LDR r0,[r1],#4
    issue(2'b11, 4'd0, 4'd1, 1'b1);
    d_src_addr = {8'h00, 4'd1};
    src0(1'b1, 4'd1);
    stg_wd[63:32] = 32'h104;
    #1;
    chk("wb_exec_stall", ld_stall, 1'b0);
    tick();
    idle();
    #1;
    chk("wb_sel",   fwd_sel, 9'd2);
    chk("wb_opnd",  e_opnd[31:0], 32'h104);
    chk("wb_stall", ld_stall, 1'b0);
    d_src_valid = '0;

    // PC is never forwarded
    issue(2'b01, 4'd15, 4'd0, 1'b0);
    tick();
    idle();
    src0(1'b1, 4'd15);
    #1;
    chk("pc_sel",  fwd_sel, 9'd0);
    chk("pc_opnd", e_opnd[31:0], 32'h1111_0001);

    // Unused source is not forwarded
    issue(2'b01, 4'd7, 4'd0, 1'b0);
    tick();
    idle();
    src0(1'b0, 4'd7);
    #1;
    chk("srcv0_sel", fwd_sel, 9'd0);
    src0(1'b1, 4'd7);
    #1;
    chk("srcv1_sel", fwd_sel, 9'd1);

    // Flushed and stalled writers do not enter slot 1
    issue(2'b01, 4'd9, 4'd0, 1'b0);
    flush_e = 1'b1;
    src0(1'b1, 4'd9);
    tick();
    chk("flush_sel", fwd_sel, 9'd0);
    flush_e = 1'b0; stall_e = 1'b1;
    tick();
    chk("stall_sel", fwd_sel, 9'd0);
    stall_e = 1'b0;

    // Reset mid-operation
    issue(2'b01, 4'd4, 4'd0, 1'b0);
    src0(1'b1, 4'd4);
    d_src_valid = 3'b001; d_src_addr = {8'h00, 4'd4};
    tick(); tick();
    chk("prerst_sel", fwd_sel, 9'd1);
    idle();
    reset = 1'b0;
    #1;
    chk("midrst_sel",   fwd_sel, 9'd0);
    chk("midrst_opnd",  e_opnd, e_rd);
    chk("midrst_stall", ld_stall, 1'b0);
    reset = 1'b1;
    tick();
    chk("postrst_sel", fwd_sel, 9'd0);
    issue(2'b01, 4'd4, 4'd0, 1'b0);
    tick();
    chk("newissue_sel", fwd_sel, 9'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard unit for the pipelined ARM core. It tracks in-flight register writes from the Execute stage down through NSTAGE later stages, with two write ports per instruction (port 0 = result Rd, port 1 = base-register writeback). For each Execute-stage source operand it selects either the register-file value or the youngest matching in-flight value. It also raises a load-use stall for Decode.

Parameters:
DW, 32, operand data width
AW, 4, register address width
NSRC, 3, number of Execute-stage source operands
NSTAGE, 2, tracked stages after Execute (slot 1 = Memory, slot NSTAGE = Writeback); legal range 1..6
LOAD_RDY, 2, slot index at which port-0 load data becomes forwardable; 1 <= LOAD_RDY <= NSTAGE
PC_REG, 15, register address that is never forwarded

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
e_valid  in  1  Execute holds a real instruction
e_we  in  2  per-port write enable of the Execute instruction
e_wa  in  2*AW  per-port destination address; port p at [p*AW +: AW]
e_is_load  in  1  port-0 result comes from memory
flush_e  in  1  kill the Execute instruction (do not enter slot 1)
stall_e  in  1  Execute holds; slot 1 receives a bubble
e_src_valid  in  NSRC  source s is used
e_src_addr  in  NSRC*AW  source addresses
e_rd  in  NSRC*DW  register-file read data per source
stg_wd  in  NSTAGE*2*DW  write data of slot k, port p at [((k-1)*2+p)*DW +: DW]
d_src_valid  in  NSRC  Decode sources used
d_src_addr  in  NSRC*AW  Decode source addresses
fwd_sel  out  NSRC*SELW  per-source select; SELW = clog2(2*NSTAGE+1)
e_opnd  out  NSRC*DW  resolved operand per source
ld_stall  out  1  stall Fetch/Decode, flush Execute

Behaviour:
- Slot descriptor: {valid, we[1:0], wa[1:0], is_load}.
- Reset (reset low, asynchronous): all slot valid bits = 0. Outputs then read fwd_sel = 0, e_opnd = e_rd, ld_stall = 0.
- Each rising edge:
  - slot k <= slot k-1 for k >= 2.
  - slot 1 <= Execute descriptor if e_valid & ~flush_e & ~stall_e; otherwise slot 1 <= bubble (valid = 0).
  - Slot NSTAGE retires.
- A slot port "hits" source s when all hold: slot valid, that port's we set, wa == src addr, e_src_valid[s], and src addr != PC_REG.
- A port-0 hit in a load slot with k < LOAD_RDY is "not ready".
- fwd_sel[s] is combinational, same cycle:
  - Scan slots k = 1..NSTAGE, youngest first; within a slot, port 0 before port 1.
  - The first ready hit gives code 1 + (k-1)*2 + p.
  - No hit gives 0.
  - A not-ready hit stops the scan and gives 0. The stall mechanism guarantees this case never reaches Execute; the verifier flags it as an assertion.
- e_opnd[s] = e_rd[s] when fwd_sel = 0; otherwise the stg_wd field indexed by the code. Zero added latency.
- ld_stall = OR over Decode sources s with d_src_valid[s] and d_src_addr != PC_REG, of either:
  - (a) Execute holds a valid, unflushed load whose port-0 address equals the source, and LOAD_RDY > 1; or
  - (b) slot k holds a load port-0 write to that address and k + 1 < LOAD_RDY.
- Port-1 results are always forwardable from slot 1 onward. Port 1 never causes a stall.
- Both ports of one instruction writing the same address: port 0 wins. No error is raised.
- stall_e and flush_e both high: bubble enters slot 1; Execute contents are irrelevant.
- Reset mid-operation clears all in-flight entries immediately. Forwarding resumes from an empty pipe.
- No state besides the slot descriptors. Data is not stored internally.

Test Plan:
- Back-to-back ALU dependency: ADD r3 then SUB using r3 as src0 next cycle (slot 1 port 0 data 0x11) -> fwd_sel[0] = 1, e_opnd[0] = 0x11. One cycle later without a new write -> fwd_sel[0] = 3 (slot 2, port 0).
- Priority: slot 1 writes r5 = 0xAA, slot 2 writes r5 = 0xBB -> fwd_sel = 1, e_opnd = 0xAA. Slot 1 with port 0 and port 1 both writing r5 -> code 1.
- Load-use, NSTAGE = 2, LOAD_RDY = 2: LDR r2 in Execute, Decode source r2 -> ld_stall = 1. Next cycle (load in slot 1, bubble in Execute) -> ld_stall = 0. Following cycle the dependent instruction is in Execute -> fwd_sel = 3, e_opnd = memory data 0xDEADBEEF.
- Base writeback: LDR r0,[r1],#4 puts r1 on port 1 with value 0x104 in slot 1; dependent source r1 -> fwd_sel = 2, e_opnd = 0x104, ld_stall = 0.
- PC and gating: source r15 while slot 1 writes r15 -> fwd_sel = 0, e_opnd = e_rd. Source with e_src_valid = 0 and a matching address -> 0. flush_e on a writing instruction -> no hit next cycle.
- Reset: populate both slots with matching writes, pull reset low mid-cycle -> fwd_sel = 0 and ld_stall = 0 immediately, before the next clock edge. After release, forwarding is seen only from new issues.
